// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised single-clock FIFO with thresholds, flush and registered status
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in, wr_en        write data and write request
//   rd_en, data_out       read request and registered read data
//   flush                 synchronous clear of pointers, count and status pulses
//   wr_ack                previous-cycle write accepted
//   overflow, underflow   previous-cycle write/read rejected
//   full, empty           occupancy at the limits
//   almostfull            count >= AFULL_TH
//   almostempty           count <= AEMPTY_TH
//   count                 current occupancy
module fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_TH   = FIFO_DEPTH - 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic                            flush,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Depth need not be a power of two, so wrap on an explicit compare
    // rather than relying on pointer truncation.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    // Acceptance uses the pre-edge occupancy only: a same-cycle read does
    // not make room for a write, and a same-cycle write cannot be read.
    assign w_wr_acc = wr_en && !w_full  && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full  && !flush;
            r_underflow <= rd_en && w_empty && !flush;

            if (flush) begin
                // data_out deliberately holds across a flush.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= ptr_next(r_wr_ptr);
                end
                if (w_rd_acc) begin
                    r_rd_ptr   <= ptr_next(r_rd_ptr);
                    r_data_out <= r_mem[r_rd_ptr];
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= CNT_W'(AFULL_TH));
    assign almostempty = (r_count <= CNT_W'(AEMPTY_TH));

endmodule
